// File: rtl/sdram_burst_scheduler_pkg.sv
// Shared types and default widths for the SDRAM burst scheduler.
package sdram_burst_scheduler_pkg;

  localparam int ASIZE_DEF = 23;
  localparam int LSIZE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_t;

  // Width of a port index; a single port still needs one bit.
  function automatic int lg_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_burst_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible port after last_grant.
module sdram_burst_scheduler_rr_pick
  import sdram_burst_scheduler_pkg::*;
#(
  parameter int NPORT = 4,
  localparam int GW = lg_width(NPORT)
) (
  input  logic [NPORT-1:0] eligible,
  input  logic [GW-1:0]    last_grant,
  output logic [NPORT-1:0] grant,
  output logic             any_valid
);

  logic [GW:0]      sh;
  logic [NPORT-1:0] rot;
  logic [NPORT-1:0] low;

  // Rotate so last_grant+1 lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    sh        = {1'b0, last_grant} + {{GW{1'b0}}, 1'b1};
    rot       = NPORT'({eligible, eligible} >> sh);
    low       = rot & (-rot);
    grant     = NPORT'(({low, low} << sh) >> NPORT);
    any_valid = |eligible;
  end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Round-robin page-burst scheduler for the multi-port SDRAM controller.
// Tracks a running address per port and hands one burst at a time to the
// command core over a req/ack/done handshake.
module sdram_burst_scheduler
  import sdram_burst_scheduler_pkg::*;
#(
  parameter int               NPORT    = 4,
  parameter int               ASIZE    = ASIZE_DEF,
  parameter int               LSIZE    = LSIZE_DEF,
  parameter logic [NPORT-1:0] WR_PORTS = NPORT'(4'b0011)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NPORT*ASIZE-1:0] PORT_START,
  input  logic [NPORT*ASIZE-1:0] PORT_MAX,
  input  logic [NPORT*LSIZE-1:0] PORT_LEN,
  input  logic [NPORT*LSIZE-1:0] PORT_LEVEL,
  input  logic [NPORT-1:0]       PORT_LOAD,
  output logic                   BURST_REQ,
  output logic                   BURST_WR,
  output logic [ASIZE-1:0]       BURST_ADDR,
  output logic [LSIZE-1:0]       BURST_LEN,
  output logic [NPORT-1:0]       BURST_PORT,
  input  logic                   BURST_ACK,
  input  logic                   BURST_DONE
);

  localparam int GW = lg_width(NPORT);

  sched_state_t      state_q;
  logic [GW-1:0]     last_grant_q;
  logic              req_q;
  logic              wr_q;
  logic [ASIZE-1:0]  addr_out_q;
  logic [LSIZE-1:0]  len_out_q;
  logic [NPORT-1:0]  port_q;

  logic [NPORT-1:0]  eligible;
  logic [NPORT-1:0]  grant;
  logic              any_valid;

  // OR-chains select the granted port's address, length and index without
  // variable indexing; grant is one-hot so at most one term is nonzero.
  logic [NPORT:0][ASIZE-1:0] addr_chain;
  logic [NPORT:0][LSIZE-1:0] len_chain;
  logic [NPORT:0][GW-1:0]    idx_chain;

  assign addr_chain[0] = '0;
  assign len_chain[0]  = '0;
  assign idx_chain[0]  = '0;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [ASIZE-1:0] start_p;
    logic [ASIZE-1:0] max_p;
    logic [ASIZE-1:0] lim_p;
    logic [ASIZE-1:0] addr_q;
    logic [LSIZE-1:0] len_p;
    logic [LSIZE-1:0] level_p;
    logic             done_p;

    assign start_p = PORT_START[p*ASIZE +: ASIZE];
    assign max_p   = PORT_MAX[p*ASIZE +: ASIZE];
    assign len_p   = PORT_LEN[p*LSIZE +: LSIZE];
    assign level_p = PORT_LEVEL[p*LSIZE +: LSIZE];

    // Write ports need a full burst buffered; read ports need room for one.
    assign eligible[p] = (len_p != '0) && !PORT_LOAD[p] &&
                         (WR_PORTS[p] ? (level_p >= len_p) : (level_p < len_p));

    // Wrap limit uses the length latched at grant, i.e. the burst just done.
    assign lim_p  = max_p - ASIZE'(len_out_q);
    assign done_p = (state_q == ST_BUSY) && BURST_DONE && port_q[p];

    assign addr_chain[p+1] = addr_chain[p] | (grant[p] ? addr_q : '0);
    assign len_chain[p+1]  = len_chain[p]  | (grant[p] ? len_p  : '0);
    assign idx_chain[p+1]  = idx_chain[p]  | (grant[p] ? GW'(p) : '0);

    // Running address: LOAD pins it to START and wins over a completing burst.
    always_ff @(posedge CLK) begin
      if (!RESET_N || PORT_LOAD[p]) begin
        addr_q <= start_p;
      end else if (done_p) begin
        addr_q <= (addr_q < lim_p) ? (addr_q + ASIZE'(len_out_q)) : start_p;
      end
    end
  end

  sdram_burst_scheduler_rr_pick #(
    .NPORT(NPORT)
  ) u_pick (
    .eligible  (eligible),
    .last_grant(last_grant_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Burst handshake FSM; burst descriptor is latched at grant and held.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GW'(NPORT - 1);
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_out_q   <= '0;
      len_out_q    <= '0;
      port_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            addr_out_q   <= addr_chain[NPORT];
            len_out_q    <= len_chain[NPORT];
            wr_q         <= |(grant & WR_PORTS);
            port_q       <= grant;
            last_grant_q <= idx_chain[NPORT];
            req_q        <= 1'b1;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (BURST_ACK) begin
            req_q   <= 1'b0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (BURST_DONE) begin
            wr_q       <= 1'b0;
            addr_out_q <= '0;
            len_out_q  <= '0;
            port_q     <= '0;
            state_q    <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BURST_REQ  = req_q;
  assign BURST_WR   = wr_q;
  assign BURST_ADDR = addr_out_q;
  assign BURST_LEN  = len_out_q;
  assign BURST_PORT = port_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Testbench for sdram_burst_scheduler: directed scenarios plus a randomized
// phase, checked against a behavioural model of arbitration and addressing.
module tb_sdram_burst_scheduler;

  localparam int NP = 4;
  localparam int AW = 23;
  localparam int LW = 8;
  localparam logic [NP-1:0] WR = 4'b0011;

  logic clk = 1'b0;
  logic rst_n;
  logic ack;
  logic done;

  logic [AW-1:0] start_a [NP];
  logic [AW-1:0] max_a   [NP];
  logic [LW-1:0] len_a   [NP];
  logic [LW-1:0] level_a [NP];
  logic          load_a  [NP];

  logic [NP*AW-1:0] port_start;
  logic [NP*AW-1:0] port_max;
  logic [NP*LW-1:0] port_len;
  logic [NP*LW-1:0] port_level;
  logic [NP-1:0]    port_load;

  logic          burst_req;
  logic          burst_wr;
  logic [AW-1:0] burst_addr;
  logic [LW-1:0] burst_len;
  logic [NP-1:0] burst_port;

  // Model state
  logic [AW-1:0] m_addr [NP];
  int            m_last;

  int n_pass  = 0;
  int n_total = 0;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign port_start[g*AW +: AW] = start_a[g];
    assign port_max[g*AW +: AW]   = max_a[g];
    assign port_len[g*LW +: LW]   = len_a[g];
    assign port_level[g*LW +: LW] = level_a[g];
    assign port_load[g]           = load_a[g];
  end

  sdram_burst_scheduler #(
    .NPORT(NP), .ASIZE(AW), .LSIZE(LW), .WR_PORTS(WR)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .PORT_START(port_start),
    .PORT_MAX  (port_max),
    .PORT_LEN  (port_len),
    .PORT_LEVEL(port_level),
    .PORT_LOAD (port_load),
    .BURST_REQ (burst_req),
    .BURST_WR  (burst_wr),
    .BURST_ADDR(burst_addr),
    .BURST_LEN (burst_len),
    .BURST_PORT(burst_port),
    .BURST_ACK (ack),
    .BURST_DONE(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit model_elig(input int p);
    if (len_a[p] == '0 || load_a[p]) return 1'b0;
    if (WR[p]) return level_a[p] >= len_a[p];
    return level_a[p] < len_a[p];
  endfunction

  function automatic int model_pick();
    for (int i = 1; i <= NP; i++) begin
      int p;
      p = (m_last + i) % NP;
      if (model_elig(p)) return p;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a, input logic [AW-1:0] s,
                                               input logic [AW-1:0] m, input logic [LW-1:0] l);
    logic [AW-1:0] lim;
    lim = m - {{(AW-LW){1'b0}}, l};
    if (a < lim) return a + {{(AW-LW){1'b0}}, l};
    return s;
  endfunction

  task automatic clear_ports();
    for (int p = 0; p < NP; p++) begin
      start_a[p] = '0; max_a[p] = 23'h1000; len_a[p] = '0; level_a[p] = '0; load_a[p] = 1'b0;
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; ack = 1'b0; done = 1'b0;
    tick();
    tick();
    for (int p = 0; p < NP; p++) m_addr[p] = start_a[p];
    m_last = NP - 1;
  endtask

  // One complete handshake for the expected port, checking the descriptor.
  task automatic run_burst(input string tag, input int exp_p, input int ack_dly,
                           input int busy_cyc, input bit load_mid);
    int n;
    logic [LW-1:0] blen;
    n = 0;
    while (burst_req !== 1'b1 && n < 32) begin
      tick();
      n++;
    end
    check({tag, " req"}, 32'(burst_req), 32'd1);
    if (burst_req !== 1'b1) return;
    check({tag, " port"}, 32'(burst_port), 32'd1 << exp_p);
    check({tag, " addr"}, 32'(burst_addr), 32'(m_addr[exp_p]));
    check({tag, " len"}, 32'(burst_len), 32'(len_a[exp_p]));
    check({tag, " wr"}, 32'(burst_wr), 32'(WR[exp_p]));
    blen = len_a[exp_p];
    repeat (ack_dly) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, " req drop"}, 32'(burst_req), 32'd0);
    repeat (busy_cyc) tick();
    check({tag, " port busy"}, 32'(burst_port), 32'd1 << exp_p);
    if (load_mid) begin
      load_a[exp_p] = 1'b1;
      m_addr[exp_p] = start_a[exp_p];
      tick();
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    if (load_mid) load_a[exp_p] = 1'b0;
    check({tag, " gap port"}, 32'(burst_port), 32'd0);
    check({tag, " gap req"}, 32'(burst_req), 32'd0);
    if (!load_mid)
      m_addr[exp_p] = model_next(m_addr[exp_p], start_a[exp_p], max_a[exp_p], blen);
    m_last = exp_p;
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; done = 1'b0;
    clear_ports();

    // Reset values and first grant on write port 0
    start_a[0] = 23'h100; len_a[0] = 8'd8; level_a[0] = 8'd8;
    hold_reset();
    check("rst req", 32'(burst_req), 32'd0);
    check("rst wr", 32'(burst_wr), 32'd0);
    check("rst addr", 32'(burst_addr), 32'd0);
    check("rst len", 32'(burst_len), 32'd0);
    check("rst port", 32'(burst_port), 32'd0);
    rst_n = 1'b1;
    tick();
    check("first req latency", 32'(burst_req), 32'd1);
    run_burst("first", 0, 0, 2, 1'b0);

    // Round robin over four eligible ports, plus DONE-to-REQ spacing
    clear_ports();
    for (int p = 0; p < NP; p++) begin
      start_a[p] = 23'(p * 32'h1000); max_a[p] = start_a[p] + 23'h800;
      len_a[p] = 8'd4; level_a[p] = WR[p] ? 8'd8 : 8'd0;
    end
    hold_reset();
    rst_n = 1'b1;
    run_burst("rr", model_pick(), 1, 1, 1'b0);
    tick();
    check("idle after gap", 32'(burst_req), 32'd0);
    tick();
    check("req 3 after done", 32'(burst_req), 32'd1);
    for (int k = 0; k < 4; k++) run_burst("rr", model_pick(), k % 2, k, 1'b0);

    // Address wrap, MAX=32 then MAX=33
    clear_ports();
    max_a[0] = 23'd32; len_a[0] = 8'd16; level_a[0] = 8'd16;
    hold_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) run_burst("wrap32", model_pick(), 0, 0, 1'b0);
    max_a[0] = 23'd33;
    hold_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) run_burst("wrap33", model_pick(), 0, 1, 1'b0);

    // Read port with a full FIFO is held off, granted once there is room
    clear_ports();
    start_a[2] = 23'h2000; len_a[2] = 8'd8; level_a[2] = 8'd8;
    hold_reset();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rd full no req", 32'(burst_req), 32'd0);
    level_a[2] = 8'd7;
    run_burst("rd room", 2, 0, 1, 1'b0);

    // LOAD during BUSY, then LOAD held to exclude the port
    clear_ports();
    start_a[0] = 23'h40;  max_a[0] = 23'h400; len_a[0] = 8'd8; level_a[0] = 8'd8;
    start_a[1] = 23'h200; max_a[1] = 23'h300; len_a[1] = 8'd8; level_a[1] = 8'd8;
    hold_reset();
    rst_n = 1'b1;
    run_burst("load busy", 0, 0, 1, 1'b1);
    run_burst("load other", model_pick(), 0, 0, 1'b0);
    run_burst("load after", model_pick(), 0, 0, 1'b0);
    load_a[0] = 1'b1;
    m_addr[0] = start_a[0];
    for (int k = 0; k < 3; k++) run_burst("load held", model_pick(), 0, 0, 1'b0);
    load_a[0] = 1'b0;

    // Reset in BUSY, then a stray DONE
    run_burst("pre rst", model_pick(), 0, 0, 1'b0);
    run_burst("pre rst", model_pick(), 0, 0, 1'b0);
    begin
      int n;
      n = 0;
      while (burst_req !== 1'b1 && n < 32) begin tick(); n++; end
      check("mid rst req seen", 32'(burst_req), 32'd1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    len_a[0] = 8'd0; len_a[1] = 8'd0;
    rst_n = 1'b0;
    tick();
    check("mid rst req", 32'(burst_req), 32'd0);
    check("mid rst port", 32'(burst_port), 32'd0);
    check("mid rst addr", 32'(burst_addr), 32'd0);
    rst_n = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("stray done req", 32'(burst_req), 32'd0);
    check("stray done port", 32'(burst_port), 32'd0);
    for (int p = 0; p < NP; p++) m_addr[p] = start_a[p];
    m_last = NP - 1;
    len_a[0] = 8'd8; len_a[1] = 8'd8;
    run_burst("post rst", model_pick(), 0, 0, 1'b0);
    run_burst("post rst", model_pick(), 0, 0, 1'b0);

    // Randomized traffic against the model
    clear_ports();
    for (int p = 0; p < NP; p++) begin
      start_a[p] = 23'($urandom_range(0, 1023) * 8);
      max_a[p]   = start_a[p] + 23'($urandom_range(16, 200));
    end
    hold_reset();
    rst_n = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int p;
      for (int q = 0; q < NP; q++) begin
        case ($urandom_range(0, 4))
          0: len_a[q] = 8'd0;
          1: len_a[q] = 8'd4;
          2: len_a[q] = 8'd8;
          default: len_a[q] = 8'd16;
        endcase
        level_a[q] = 8'($urandom_range(0, 31));
        load_a[q]  = ($urandom_range(0, 9) == 0);
        if (load_a[q]) m_addr[q] = start_a[q];
      end
      p = model_pick();
      if (p < 0) begin
        repeat (3) tick();
        check("rand idle", 32'(burst_req), 32'd0);
      end else begin
        run_burst("rand", p, $urandom_range(0, 3), $urandom_range(0, 4),
                  ($urandom_range(0, 7) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
